// File: rtl/alu_stage_pkg.sv
// Shared types for the ALU operand/writeback stage:
// FSM states, ALU opcodes, shifter codes and the latched command bundle.
package alu_stage_pkg;

  localparam int XLEN     = 16;
  localparam int RF_DEPTH = 8;
  localparam int RF_AW    = $clog2(RF_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    WRITE
  } state_t;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    AND  = 2'b10,
    NOTB = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    LSL1 = 2'b01,
    LSR1 = 2'b10,
    ASR1 = 2'b11
  } shift_t;

  typedef struct packed {
    logic [RF_AW-1:0] rn;
    logic [RF_AW-1:0] rm;
    logic [RF_AW-1:0] rd;
    alu_op_t          op;
    shift_t           shift;
    logic             asel;
    logic             bsel;
    logic [4:0]       imm5;
  } cmd_t;

endpackage

// File: rtl/regfile_8x16.sv
// Register file: one synchronous write port, operand and debug
// combinational read ports, asynchronous clear.
module regfile_8x16
  import alu_stage_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int NREGS  = RF_DEPTH,
  parameter int AW     = RF_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata    = mem[raddr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Sequenced operand fetch / writeback around an external 16-bit ALU.
// Optional N/V status flags: define ALU_STAGE_STATUS_NV_EN.
module alu_operand_stage
  import alu_stage_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int NREGS  = RF_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [RF_AW-1:0]  rn,
  input  logic [RF_AW-1:0]  rm,
  input  logic [RF_AW-1:0]  rd,
  input  logic [1:0]        op,
  input  logic [1:0]        shift,
  input  logic              asel,
  input  logic              bsel,
  input  logic [4:0]        imm5,
  input  logic              ext_we,
  input  logic [RF_AW-1:0]  ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic [RF_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic [DATA_W-1:0] Ain,
  output logic [DATA_W-1:0] Bin,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] C,
  output logic              status_z,
`ifdef ALU_STAGE_STATUS_NV_EN
  output logic              status_n,
  output logic              status_v,
`endif
  output logic              busy,
  output logic              done
);

  state_t            state;
  state_t            state_nxt;
  cmd_t              cmd;
  logic              idle;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] b_sh;
  logic [DATA_W-1:0] rf_rdata;
  logic [RF_AW-1:0]  rf_raddr;
  logic              rf_we;
  logic [RF_AW-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign idle = (state == IDLE);
  assign busy = !idle;
  assign done = (state == WRITE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD_A;
      LOAD_A:  state_nxt = LOAD_B;
      LOAD_B:  state_nxt = EXEC;
      EXEC:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd <= '0;
    end else if (idle && start) begin
      cmd <= '{rn: rn, rm: rm, rd: rd,
               op: alu_op_t'(op),
               shift: shift_t'(shift),
               asel: asel, bsel: bsel,
               imm5: imm5};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (state == LOAD_A) a_q <= rf_rdata;
      if (state == LOAD_B) b_q <= rf_rdata;
    end
  end

  // External writes land in IDLE, so a same-edge start sees them in LOAD_A.
  assign rf_raddr = (state == LOAD_B) ? cmd.rm : cmd.rn;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ext_waddr;
    rf_wdata = ext_wdata;
    if (state == WRITE) begin
      rf_we    = 1'b1;
      rf_waddr = cmd.rd;
      rf_wdata = C;
    end else if (idle && ext_we) begin
      rf_we    = 1'b1;
    end
  end

  regfile_8x16 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (RF_AW)
  ) u_rf (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr    (rf_raddr),
    .rdata    (rf_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    b_sh = b_q;
    unique case (cmd.shift)
      NONE: b_sh = b_q;
      LSL1: b_sh = {b_q[DATA_W-2:0], 1'b0};
      LSR1: b_sh = {1'b0, b_q[DATA_W-1:1]};
      ASR1: b_sh = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
    endcase
  end

  assign Ain   = cmd.asel ? '0 : a_q;
  assign Bin   = cmd.bsel ? {{(DATA_W-5){cmd.imm5[4]}}, cmd.imm5} : b_sh;
  assign ALUop = cmd.op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      C        <= '0;
      status_z <= 1'b0;
    end else if (state == EXEC) begin
      C        <= alu_out;
      status_z <= alu_z;
    end
  end

`ifdef ALU_STAGE_STATUS_NV_EN
  logic ovf;

  always_comb begin
    ovf = 1'b0;
    unique case (cmd.op)
      ADD:  ovf = (Ain[DATA_W-1] == Bin[DATA_W-1]) &&
                  (alu_out[DATA_W-1] != Ain[DATA_W-1]);
      SUB:  ovf = (Ain[DATA_W-1] != Bin[DATA_W-1]) &&
                  (alu_out[DATA_W-1] != Ain[DATA_W-1]);
      AND:  ovf = 1'b0;
      NOTB: ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_n <= 1'b0;
      status_v <= 1'b0;
    end else if (state == EXEC) begin
      status_n <= alu_out[DATA_W-1];
      status_v <= ovf;
    end
  end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: external ALU model, transaction-level
// reference model with per-cycle compare, and directed literal checks.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  rn = '0, rm = '0, rd = '0;
  logic [1:0]  op = '0, shift = '0;
  logic        asel = 1'b0, bsel = 1'b0;
  logic [4:0]  imm5 = '0;
  logic        ext_we = 1'b0;
  logic [2:0]  ext_waddr = '0;
  logic [15:0] ext_wdata = '0;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data, alu_out, Ain, Bin, C;
  logic        alu_z, status_z, busy, done;
  logic [1:0]  ALUop;
`ifdef ALU_STAGE_STATUS_NV_EN
  logic        status_n, status_v;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rn(rn), .rm(rm), .rd(rd), .op(op), .shift(shift),
    .asel(asel), .bsel(bsel), .imm5(imm5),
    .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_out(alu_out), .alu_z(alu_z),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop),
    .C(C), .status_z(status_z),
`ifdef ALU_STAGE_STATUS_NV_EN
    .status_n(status_n), .status_v(status_v),
`endif
    .busy(busy), .done(done)
  );

  function automatic logic [15:0] alu_f(input logic [1:0] o,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    case (o)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return ~b;
    endcase
  endfunction

  // Shifts expressed as arithmetic on the unsigned value.
  function automatic logic [15:0] shf(input logic [1:0] s,
                                      input logic [15:0] b);
    int v;
    v = int'(b);
    case (s)
      2'b00:   return b;
      2'b01:   return 16'((v * 2) % 65536);
      2'b10:   return 16'(v / 2);
      default: return 16'(v / 2 + ((v >= 32768) ? 32768 : 0));
    endcase
  endfunction

  function automatic logic [15:0] sx(input logic [4:0] i);
    int v;
    v = int'(i);
    if (v >= 16) v = v - 32;
    return 16'(v);
  endfunction

  function automatic int sv16(input logic [15:0] x);
    return (int'(x) >= 32768) ? int'(x) - 65536 : int'(x);
  endfunction

  function automatic logic ovf_f(input logic [1:0] o,
                                 input logic [15:0] a,
                                 input logic [15:0] b);
    int r;
    if (o == 2'b00) r = sv16(a) + sv16(b);
    else if (o == 2'b01) r = sv16(a) - sv16(b);
    else return 1'b0;
    return (r > 32767) || (r < -32768);
  endfunction

  assign alu_out = alu_f(ALUop, Ain, Bin);
  assign alu_z   = (alu_out == 16'h0000);

  // Reference model: cnt counts remaining cycles of the operation.
  logic [15:0] mr [8];
  int          cnt = 0;
  logic [15:0] m_ain = '0, m_bin = '0, m_res = '0, m_c = '0;
  logic        m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;
  logic [1:0]  m_op = '0;
  logic [2:0]  m_rd = '0;
  logic [15:0] fa, fb, n_ain, n_bin;

  initial for (int i = 0; i < 8; i++) mr[i] = '0;

  always_comb begin
    fa = (ext_we && ext_waddr == rn) ? ext_wdata : mr[rn];
    fb = (ext_we && ext_waddr == rm) ? ext_wdata : mr[rm];
    n_ain = asel ? 16'h0000 : fa;
    n_bin = bsel ? sx(imm5) : shf(shift, fb);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) mr[i] <= '0;
      cnt <= 0;
      m_ain <= '0; m_bin <= '0; m_res <= '0; m_c <= '0;
      m_z <= 1'b0; m_n <= 1'b0; m_v <= 1'b0;
      m_op <= '0; m_rd <= '0;
    end else if (cnt == 0) begin
      if (ext_we) mr[ext_waddr] <= ext_wdata;
      if (start) begin
        m_ain <= n_ain;
        m_bin <= n_bin;
        m_res <= alu_f(op, n_ain, n_bin);
        m_op  <= op;
        m_rd  <= rd;
        cnt   <= 4;
      end
    end else begin
      if (cnt == 2) begin
        m_c <= m_res;
        m_z <= (m_res == 16'h0000);
        m_n <= m_res[15];
        m_v <= ovf_f(m_op, m_ain, m_bin);
      end
      if (cnt == 1) mr[m_rd] <= m_c;
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(cnt != 0));
    chk("done", 32'(done), 32'(cnt == 1));
    chk("C", 32'(C), 32'(m_c));
    chk("status_z", 32'(status_z), 32'(m_z));
    chk("ALUop", 32'(ALUop), 32'(m_op));
    chk("dbg", 32'(dbg_data), 32'(mr[dbg_addr]));
    if (cnt <= 2) begin
      chk("Ain", 32'(Ain), 32'(m_ain));
      chk("Bin", 32'(Bin), 32'(m_bin));
    end
`ifdef ALU_STAGE_STATUS_NV_EN
    chk("status_n", 32'(status_n), 32'(m_n));
    chk("status_v", 32'(status_v), 32'(m_v));
`endif
  end

  task automatic ext_write(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #2;
    ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
    @(posedge clk); #2;
    ext_we = 1'b0;
  endtask

  task automatic peek(input string name, input logic [2:0] a,
                      input logic [15:0] exp);
    #2;
    dbg_addr = a;
    #1;
    chk(name, 32'(dbg_data), 32'(exp));
  endtask

  // mode 0: plain; 1: start+ext_we in LOAD_B; 2: reset in EXEC.
  task automatic run_op(
    input logic [2:0] a_rn, input logic [2:0] a_rm, input logic [2:0] a_rd,
    input logic [1:0] a_op, input logic [1:0] a_sh,
    input logic a_asel, input logic a_bsel, input logic [4:0] a_imm,
    input logic a_ext, input logic [2:0] a_wa, input logic [15:0] a_wd,
    input int mode, output int dones, output int done_at,
    output logic [15:0] ex_ain, output logic [15:0] ex_bin);
    @(posedge clk); #2;
    rn = a_rn; rm = a_rm; rd = a_rd; op = a_op; shift = a_sh;
    asel = a_asel; bsel = a_bsel; imm5 = a_imm;
    ext_we = a_ext; ext_waddr = a_wa; ext_wdata = a_wd;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; ext_we = 1'b0;
    dones = 0; done_at = -1; ex_ain = '0; ex_bin = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) begin dones++; done_at = i; end
      if (i == 2) begin ex_ain = Ain; ex_bin = Bin; end
      if (mode == 1 && i == 1) begin
        #2; start = 1'b1; ext_we = 1'b1;
        ext_waddr = 3'd5; ext_wdata = 16'h1234;
      end
      if (mode == 1 && i == 2) begin
        #2; start = 1'b0; ext_we = 1'b0;
      end
      if (mode == 2 && i == 2) begin
        #2; reset_n = 1'b0; #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_C", 32'(C), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
      end
      if (mode == 2 && i == 3) begin
        #2; reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    int dn, dat;
    logic [15:0] xa, xb;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_Ain", 32'(Ain), 32'd0);
    chk("rst_C", 32'(C), 32'd0);
    reset_n = 1'b1;

    ext_write(3'd0, 16'd3);
    ext_write(3'd1, 16'd3);
    run_op(0, 1, 2, 2'b00, 2'b00, 0, 0, 5'd0, 0, 0, 0, 0, dn, dat, xa, xb);
    chk("add_dones", 32'(dn), 32'd1);
    chk("add_done_at", 32'(dat), 32'd3);
    chk("add_C", 32'(C), 32'h0006);
    chk("add_z", 32'(status_z), 32'd0);
    peek("add_R2", 3'd2, 16'h0006);

    run_op(0, 1, 3, 2'b01, 2'b00, 0, 0, 5'd0, 0, 0, 0, 0, dn, dat, xa, xb);
    chk("sub_C", 32'(C), 32'h0000);
    chk("sub_z", 32'(status_z), 32'd1);
    peek("sub_R3", 3'd3, 16'h0000);

    ext_write(3'd1, 16'h8001);
    run_op(0, 1, 6, 2'b11, 2'b11, 0, 0, 5'd0, 0, 0, 0, 0, dn, dat, xa, xb);
    chk("asr_Bin", 32'(xb), 32'hC000);
    chk("not_C", 32'(C), 32'h3FFF);
    chk("not_z", 32'(status_z), 32'd0);

    run_op(0, 1, 4, 2'b00, 2'b00, 1, 1, 5'b11110, 0, 0, 0, 0,
           dn, dat, xa, xb);
    chk("imm_Ain", 32'(xa), 32'h0000);
    chk("imm_Bin", 32'(xb), 32'hFFFE);
    peek("imm_R4", 3'd4, 16'hFFFE);

    run_op(7, 7, 7, 2'b00, 2'b01, 0, 0, 5'd0, 1, 7, 16'h0005, 0,
           dn, dat, xa, xb);
    chk("fwd_C", 32'(C), 32'h000F);
    peek("fwd_R7", 3'd7, 16'h000F);

    run_op(0, 0, 1, 2'b00, 2'b00, 0, 0, 5'd0, 0, 0, 0, 1, dn, dat, xa, xb);
    chk("busy_dones", 32'(dn), 32'd1);
    chk("busy_C", 32'(C), 32'h0006);
    peek("busy_R5", 3'd5, 16'h0000);
    peek("busy_R1", 3'd1, 16'h0006);

    run_op(0, 1, 2, 2'b10, 2'b10, 0, 0, 5'd0, 0, 0, 0, 0, dn, dat, xa, xb);
    chk("lsr_Bin", 32'(xb), 32'h0003);
    chk("and_C", 32'(C), 32'h0003);

    run_op(0, 1, 5, 2'b00, 2'b00, 0, 0, 5'd0, 0, 0, 0, 2, dn, dat, xa, xb);
    chk("abort_dones", 32'(dn), 32'd0);
    chk("abort_C_after", 32'(C), 32'd0);
    peek("abort_R5", 3'd5, 16'h0000);
    peek("abort_R0", 3'd0, 16'h0000);

`ifdef ALU_STAGE_STATUS_NV_EN
    ext_write(3'd0, 16'h7FFF);
    ext_write(3'd1, 16'h0001);
    run_op(0, 1, 2, 2'b00, 2'b00, 0, 0, 5'd0, 0, 0, 0, 0, dn, dat, xa, xb);
    chk("nv_C", 32'(C), 32'h8000);
    chk("nv_n", 32'(status_n), 32'd1);
    chk("nv_v", 32'(status_v), 32'd1);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
